// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg
// Shared definitions for the PS/2 mouse packet decoder:
//   - state_t      : packet framing FSM states
//   - HDR_*        : bit positions inside the PS/2 header byte
//   - DELTA9_MAX/MIN : 9-bit movement limits used when an axis overflows
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_X   = 2'd1,
        S_Y   = 2'd2,
        S_Z   = 2'd3
    } state_t;

    localparam int HDR_L    = 0;
    localparam int HDR_R    = 1;
    localparam int HDR_M    = 2;
    localparam int HDR_SYNC = 3;
    localparam int HDR_XS   = 4;
    localparam int HDR_YS   = 5;
    localparam int HDR_XO   = 6;
    localparam int HDR_YO   = 7;

    localparam logic signed [8:0] DELTA9_MAX = 9'sh0FF;  // +255
    localparam logic signed [8:0] DELTA9_MIN = 9'sh100;  // -256

endpackage

// File: rtl/ps2_mouse_delta_ext.sv
// ps2_mouse_delta_ext
// Combinational decode of one movement axis: builds the 9-bit two's
// complement value {sign, data}, saturates it when the overflow flag is
// set, then sign-extends to DELTA_W bits.
// Ports:
//   sign  in  1        axis sign bit from the header
//   ovf   in  1        axis overflow bit from the header
//   data  in  8        axis movement byte
//   delta out DELTA_W  decoded signed movement
module ps2_mouse_delta_ext
    import ps2_mouse_pkg::*;
#(
    parameter int DELTA_W = 12
) (
    input  logic               sign,
    input  logic               ovf,
    input  logic [7:0]         data,
    output logic [DELTA_W-1:0] delta
);

    logic signed [8:0] v9;

    always_comb begin
        v9 = {sign, data};
        // An overflowed axis carries a meaningless byte; clamp to the
        // extreme in the direction the sign bit indicates.
        if (ovf) begin
            v9 = sign ? DELTA9_MIN : DELTA9_MAX;
        end
    end

    // Size cast of a signed operand sign-extends.
    assign delta = DELTA_W'(v9);

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder
// Turns the PS/2 receiver byte stream into decoded mouse packets on a
// valid/ready interface. Handles 3-byte and 4-byte (IntelliMouse wheel)
// packets, resyncs on a bad header or an inter-byte timeout, and counts
// packets dropped while the consumer holds off.
// Optional feature macro: PS2_MOUSE_ACCUM_EN adds clamped absolute
// position accumulators (pos_x/pos_y ports).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ps2_byte/_en        received byte and its one-cycle strobe
//   wheel_mode          1 = 4-byte packets, sampled at each header
//   pkt_valid/ready     output handshake
//   buttons             {M,R,L}
//   delta_x/y/z         signed movement (y is +up, z is 0 in 3-byte mode)
//   x_ovf/y_ovf         header overflow flags of the held packet
//   sync_err            one-cycle pulse on bad header or timeout
//   drop_cnt            saturating count of packets lost to backpressure
//   pos_x/pos_y         accumulated position (PS2_MOUSE_ACCUM_EN only)
module ps2_mouse_packet_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int DELTA_W        = 12,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DROP_W         = 8,
    parameter int POS_W          = 11,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         ps2_byte,
    input  logic               ps2_byte_en,
    input  logic               wheel_mode,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output logic [2:0]         buttons,
    output logic [DELTA_W-1:0] delta_x,
    output logic [DELTA_W-1:0] delta_y,
    output logic [3:0]         delta_z,
    output logic               x_ovf,
    output logic               y_ovf,
    output logic               sync_err,
    output logic [DROP_W-1:0]  drop_cnt
`ifdef PS2_MOUSE_ACCUM_EN
    ,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y
`endif
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Elaboration-time parameter sanity.
    if (DELTA_W < 9 || TIMEOUT_CYCLES < 2 || DROP_W < 1 || POS_W + 2 < 9 ||
        X_MAX < 0 || Y_MAX < 0 || X_MAX >= (1 << POS_W) || Y_MAX >= (1 << POS_W)) begin : g_bad_param
        $error("ps2_mouse_packet_decoder: illegal parameter combination");
    end

    state_t            state_q, state_d;
    logic [7:0]        hdr_q, x_q, y_q;
    logic              mode_q;
    logic [TO_W-1:0]   to_cnt;

    logic              timeout, hdr_err, complete, load, drop;
    logic [7:0]        y_byte;
    logic [3:0]        z_val;
    logic [DELTA_W-1:0] dx_dec, dy_dec;

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_HDR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        hdr_err  = 1'b0;
        complete = 1'b0;
        // Timeout wins over a byte in the same cycle: that byte is lost.
        timeout  = (state_q != S_HDR) && (to_cnt == TO_LAST);
        if (timeout) begin
            state_d = S_HDR;
        end else if (ps2_byte_en) begin
            case (state_q)
                S_HDR: begin
                    if (ps2_byte[HDR_SYNC]) state_d = S_X;
                    else                    hdr_err = 1'b1;
                end
                S_X: state_d = S_Y;
                S_Y: begin
                    if (mode_q) begin
                        state_d = S_Z;
                    end else begin
                        state_d  = S_HDR;
                        complete = 1'b1;
                    end
                end
                S_Z: begin
                    state_d  = S_HDR;
                    complete = 1'b1;
                end
                default: state_d = S_HDR;
            endcase
        end
        load = complete && (!pkt_valid || pkt_ready);
        drop = complete && !load;
    end

    // ------------------------------------------------------------------
    // Packet assembly. The completing byte is used straight off the bus
    // so the output register can load in the same cycle.
    // ------------------------------------------------------------------
    assign y_byte = (state_q == S_Y) ? ps2_byte : y_q;
    assign z_val  = (state_q == S_Z) ? ps2_byte[3:0] : 4'd0;

    ps2_mouse_delta_ext #(.DELTA_W(DELTA_W)) u_dx (
        .sign  (hdr_q[HDR_XS]),
        .ovf   (hdr_q[HDR_XO]),
        .data  (x_q),
        .delta (dx_dec)
    );

    ps2_mouse_delta_ext #(.DELTA_W(DELTA_W)) u_dy (
        .sign  (hdr_q[HDR_YS]),
        .ovf   (hdr_q[HDR_YO]),
        .data  (y_byte),
        .delta (dy_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            mode_q   <= 1'b0;
            to_cnt   <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= hdr_err | timeout;
            if (state_q == S_HDR || timeout || ps2_byte_en) to_cnt <= '0;
            else                                            to_cnt <= to_cnt + 1'b1;
            if (ps2_byte_en && !timeout) begin
                case (state_q)
                    S_HDR: begin
                        if (ps2_byte[HDR_SYNC]) begin
                            hdr_q  <= ps2_byte;
                            mode_q <= wheel_mode;
                        end
                    end
                    S_X:     x_q <= ps2_byte;
                    S_Y:     y_q <= ps2_byte;
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_valid <= 1'b0;
            buttons   <= '0;
            delta_x   <= '0;
            delta_y   <= '0;
            delta_z   <= '0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (load) begin
                pkt_valid <= 1'b1;
                buttons   <= {hdr_q[HDR_M], hdr_q[HDR_R], hdr_q[HDR_L]};
                delta_x   <= dx_dec;
                delta_y   <= dy_dec;
                delta_z   <= z_val;
                x_ovf     <= hdr_q[HDR_XO];
                y_ovf     <= hdr_q[HDR_YO];
            end else if (pkt_ready) begin
                pkt_valid <= 1'b0;
            end
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef PS2_MOUSE_ACCUM_EN
    // ------------------------------------------------------------------
    // Position accumulators. Two guard bits keep the sum from wrapping
    // before the clamp; every completed packet counts, dropped or not.
    // ------------------------------------------------------------------
    localparam int AW = POS_W + 2;

    logic signed [AW-1:0] sum_x, sum_y;

    always_comb begin
        sum_x = $signed({2'b00, pos_x}) + AW'($signed(dx_dec));
        sum_y = $signed({2'b00, pos_y}) - AW'($signed(dy_dec));  // screen Y-down
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (complete) begin
            if (sum_x < 0)                pos_x <= '0;
            else if (sum_x > AW'(X_MAX))  pos_x <= POS_W'(X_MAX);
            else                          pos_x <= sum_x[POS_W-1:0];
            if (sum_y < 0)                pos_y <= '0;
            else if (sum_y > AW'(Y_MAX))  pos_y <= POS_W'(Y_MAX);
            else                          pos_y <= sum_y[POS_W-1:0];
        end
    end
`endif

endmodule

// File: doc/ps2_mouse_packet_decoder.md
Name: ps2_mouse_packet_decoder

Overview:
Second-generation PS/2 mouse packet decoder. It sits downstream of the PS/2 byte receiver and turns the raw byte stream into decoded mouse packets, presented on a valid/ready interface. Both packet formats are supported: standard 3-byte packets and IntelliMouse 4-byte packets with a wheel byte. Compared with the first-generation parser it adds width-parametrised sign extension, overflow saturation, inter-byte timeout resync, error reporting and backpressure with a drop counter.

Parameters:
DELTA_W, 12, width of signed delta_x/delta_y outputs; must be >= 9.
TIMEOUT_CYCLES, 100000, idle clk cycles allowed between bytes of one packet before resync.
DROP_W, 8, width of the saturating drop counter.
POS_W, 11, accumulated position width (used only with PS2_MOUSE_ACCUM_EN).
X_MAX, 639, upper clamp for pos_x (only with PS2_MOUSE_ACCUM_EN).
Y_MAX, 479, upper clamp for pos_y (only with PS2_MOUSE_ACCUM_EN).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ps2_byte  in  8  received PS/2 byte
ps2_byte_en  in  1  one-cycle strobe: ps2_byte valid
wheel_mode  in  1  1 = 4-byte IntelliMouse packets, 0 = 3-byte packets
pkt_valid  out  1  decoded packet available
pkt_ready  in  1  consumer accepts packet
buttons  out  3  {M,R,L}
delta_x  out  DELTA_W  signed X movement (two's complement)
delta_y  out  DELTA_W  signed Y movement (PS/2 convention, +up)
delta_z  out  4  signed wheel movement; 0 in 3-byte mode
x_ovf  out  1  X overflow flag of the packet
y_ovf  out  1  Y overflow flag of the packet
sync_err  out  1  one-cycle pulse on framing error or timeout
drop_cnt  out  DROP_W  packets dropped because of backpressure, saturating
pos_x  out  POS_W  accumulated X position (only with PS2_MOUSE_ACCUM_EN)
pos_y  out  POS_W  accumulated Y position (only with PS2_MOUSE_ACCUM_EN)

Behaviour:
- Reset values: every output is 0, the FSM is in S_HDR, and the timeout counter is 0.
- FSM states: S_HDR, S_X, S_Y, S_Z. The FSM advances only on ps2_byte_en.
- S_HDR:
  - If ps2_byte[3]=1: latch the header, latch wheel_mode into the packet-local mode_q, go to S_X.
  - If ps2_byte[3]=0: discard the byte, pulse sync_err, stay in S_HDR.
- S_X: latch the X byte, go to S_Y.
- S_Y: latch the Y byte. If mode_q=1 go to S_Z; otherwise the packet is complete and the FSM returns to S_HDR.
- S_Z: latch the Z byte. The packet is complete and the FSM returns to S_HDR.
- Changes to wheel_mode mid-packet have no effect until the next header.
- Timeout:
  - In any state other than S_HDR, the counter increments each cycle with no ps2_byte_en and clears on ps2_byte_en.
  - When it reaches TIMEOUT_CYCLES-1: go to S_HDR, pulse sync_err, clear the counter, discard the partial packet.
  - A ps2_byte_en arriving in that same cycle is treated as a header in S_HDR on the following cycle; that byte itself is lost.
- Delta decode, per axis, from the 9-bit value {sign, byte}:
  - If the axis overflow bit (hdr[6] for X, hdr[7] for Y) is set: the result saturates to +255 when sign=0, or -256 when sign=1.
  - Otherwise the result is {sign, byte}.
  - The result is then sign-extended to DELTA_W.
- delta_z = Z byte[3:0], interpreted as signed. Z byte[7:4] is ignored.
- Completion and output register:
  - On the completing byte's ps2_byte_en cycle (cycle N), the output register loads if pkt_valid=0 or pkt_ready=1 in cycle N. pkt_valid is then 1 in cycle N+1.
  - Otherwise the new packet is dropped, the held packet is unchanged, and drop_cnt increments with saturation at all-ones.
- Handshake: a transfer occurs when pkt_valid and pkt_ready are both 1. After a transfer with no simultaneous load, pkt_valid=0 next cycle. Outputs are stable while pkt_valid=1 and pkt_ready=0.
- sync_err is never asserted in the same cycle as packet completion.
- Reset asserted mid-packet discards the partial packet and any held packet.

Optional Feature:
PS2_MOUSE_ACCUM_EN.
- Defined:
  - pos_x/pos_y are unsigned accumulators updated on every completed packet, including dropped ones.
  - pos_x ← clamp(pos_x + delta_x, 0, X_MAX).
  - pos_y ← clamp(pos_y - delta_y, 0, Y_MAX), giving screen Y-down.
  - Arithmetic is done at POS_W+2 bits signed before clamping.
  - The new position is visible in cycle N+1.
- Undefined: the pos_x/pos_y ports are absent and no accumulator logic is built.

Decomposition:
- Package ps2_mouse_pkg holds:
  - the FSM state enum;
  - header bit-position constants (L=0, R=1, M=2, SYNC=3, XS=4, YS=5, XO=6, YO=7);
  - the 9-bit saturation limits DELTA9_MAX=255 and DELTA9_MIN=-256.
- Sub-module ps2_mouse_delta_ext: combinational saturate-and-sign-extend, parametrised by DELTA_W, with inputs sign/ovf/byte. It is instantiated once for X and once for Y.

Test Plan:
- wheel_mode=0, bytes 0x29, 0x05, 0xFB, pkt_ready=1 -> one cycle after the 3rd strobe: pkt_valid=1, buttons=001, delta_x=0x005, delta_y=0xFFB (-5), delta_z=0.
- Bytes 0x58, 0x10, 0x00 -> x_ovf=1, delta_x=0xF00 (-256), y_ovf=0, delta_y=0x000.
- Byte 0x00 in S_HDR -> sync_err pulse, no packet. Then 0x08, 0x01, 0x02 -> valid packet with delta_x=1, delta_y=2.
- Bytes 0x08, 0x10, then silence for TIMEOUT_CYCLES (set to 50 in the bench) -> sync_err pulse and FSM in S_HDR. Then 0x09, 0x00, 0x00 -> buttons=001.
- pkt_ready=0, two complete packets -> first packet held unchanged, drop_cnt=1. Then pkt_ready=1 -> first packet transfers and pkt_valid=0.
- wheel_mode=1, bytes 0x08, 0x01, 0x02, 0x0F -> pkt_valid only after the 4th strobe, delta_z=-1. With ACCUM enabled (from reset): pos_x=1, pos_y=0 (clamped).
